axi_ram_slave: RTL and testbench
================================

// Module: axi_ram_slave
// PURPOSE
//  AXI-style responder backed by on-chip block RAM. Port-compatible with the AXI side of the sdram ip.
//  Serves as a drop-in fast target for AXI masters and as a golden reference memory in benches.
//  Accepts INCR/FIXED bursts of 1..256 16-bit beats. There is no B channel, no wlast and no rlast;
//  burst length is carried only by awlen/arlen.
// PARAMETERS
//  ADDR_W    22  word-address width of axi_awaddr/axi_araddr
//  DATA_W    16  data width; DATA_W/8 strobe bits
//  ID_W      8   width of axi_awid/axi_arid (accepted, ignored)
//  DEPTH_LG2 12  log2 of RAM depth in words; address bits above this are ignored
// PORTS
//  clk          in  1        single clock, all logic on posedge
//  reset        in  1        asynchronous, active-low reset
//  axi_awid     in  ID_W     write id (ignored)
//  axi_awaddr   in  ADDR_W   write start word address
//  axi_awlen    in  8        beats-1
//  axi_awsize   in  3        ignored (always 16-bit)
//  axi_awburst  in  2        00 FIXED, 01 INCR, others treated as INCR
//  axi_awvalid  in  1        write address valid
//  axi_awready  out 1        write address ready
//  axi_wdata    in  DATA_W   write data
//  axi_wstrb    in  DATA_W/8 byte enables
//  axi_wvalid   in  1        write data valid
//  axi_wready   out 1        write data ready
//  axi_arid     in  ID_W     read id (ignored)
//  axi_araddr   in  ADDR_W   read start word address
//  axi_arlen    in  8        beats-1
//  axi_arsize   in  3        ignored
//  axi_arburst  in  2        as awburst
//  axi_arvalid  in  1        read address valid
//  axi_arready  out 1        read address ready
//  axi_rdata    out DATA_W   read data
//  axi_rvalid   out 1        read data valid
//  axi_rready   in  1        read data accept
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; awready=arready=1; wready=rvalid=0; rdata=0; counters=0.
//   RAM contents are not cleared. Reset mid-burst abandons the burst; beats already written stay.
//  FSM IDLE -> WR_DATA | RD_ADDR -> RD_DATA -> IDLE; exactly one burst is outstanding at a time.
//  IDLE: awready=arready=1.
//   - awvalid=1: latch addr/len/burst; awready=arready=0 next cycle; go to WR_DATA.
//   - arvalid=1 (awvalid=0): latch; awready=arready=0 next cycle; go to RD_ADDR.
//   - Both valid in the same cycle: write wins; read waits for the next IDLE.
//  WR_DATA: wready=1 until all awlen+1 beats are taken.
//   - Each cycle with wvalid=1 writes wdata under wstrb at the current address, then
//     INCR: addr+1, FIXED: addr unchanged.
//   - Beat counter is 9 bits. When the count reaches awlen+1: wready=0, go to IDLE (ready=1 next cycle).
//   - wvalid while not in WR_DATA is ignored.
//  RD_ADDR: one cycle; issues the RAM read of the first beat.
//  RD_DATA: rvalid=1 with data. First rvalid is 2 cycles after the arvalid-accept edge.
//   - rready=1 sustains 1 beat/cycle, using read-ahead plus a 1-entry skid register.
//   - rready=0 holds rdata/rvalid stable.
//   - After beat arlen+1 is accepted: rvalid=0, go to IDLE.
//  Address: word address; RAM index = addr[DEPTH_LG2-1:0]. An INCR burst crossing the top wraps to 0.
//  Read-after-write: a read issued after the write burst returns the new data. No same-cycle collisions exist.
// STRUCTURE
//  axi_ram_pkg: state_t enum {IDLE,WR_DATA,RD_ADDR,RD_DATA}; BURST_FIXED=2'b00, BURST_INCR=2'b01.
//  Sub-module sdp_ram_be: simple dual-port RAM with byte enables, registered read (1-cycle latency),
//   parameters DATA_W and DEPTH_LG2.
//  Top level holds the FSM, address/beat counters and the read skid register.
// TESTING
//  1. Reset release -> awready=arready=1, wready=rvalid=0.
//     Single write addr 0x000010, data 0xA5A5, then read len 1 -> rdata=0xA5A5 exactly 2 cycles after accept.
//  2. INCR write awlen=255, data 0..255 from 0x000100; read arlen=255 with rready held high
//     -> 256 consecutive rvalid cycles, data 0..255.
//  3. Read 8 beats with rready toggled 1-0-1-0 -> rdata stays stable while rready=0; no beat lost or duplicated.
//  4. awvalid and arvalid asserted together -> write served first, read served after;
//     read returns the freshly written data.
//  5. INCR write 4 beats at 0x000FFE (DEPTH_LG2=12) -> data lands at 0xFFE, 0xFFF, 0x000, 0x001.
//     FIXED write 3 beats -> only the last beat survives at the start address.
//  6. wstrb=2'b01 over 0x1234 with new data 0xBEEF -> reads 0x12EF.
//     Reset asserted mid-burst -> outputs take reset values immediately; next transaction completes normally.

Source files
------------

// File: rtl/axi_ram_pkg.sv
// Shared types and burst helpers for the AXI block-RAM responder.
package axi_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        RD_ADDR,
        RD_DATA
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Address increment per beat; reserved burst codes behave as INCR.
    function automatic logic burst_step(input logic [1:0] burst);
        case (burst)
            BURST_FIXED: return 1'b0;
            BURST_INCR:  return 1'b1;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
module sdp_ram_be #(
    parameter int DATA_W    = 16,
    parameter int DEPTH_LG2 = 12
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [DEPTH_LG2-1:0]   waddr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [DATA_W/8-1:0]    wbe_i,
    input  logic                   re_i,
    input  logic [DEPTH_LG2-1:0]   raddr_i,
    output logic [DATA_W-1:0]      rdata_o
);

    logic [DATA_W-1:0] mem [1<<DEPTH_LG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (we_i && wbe_i[b]) begin
                mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI-style burst responder over block RAM: one burst at a time, read-ahead
// with a one-entry skid so reads stream at one beat per cycle under backpressure.
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int ID_W      = 8,
    parameter int DEPTH_LG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_W-1:0]       axi_awid,
    input  logic [ADDR_W-1:0]     axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_W-1:0]     axi_wdata,
    input  logic [DATA_W/8-1:0]   axi_wstrb,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic [ID_W-1:0]       axi_arid,
    input  logic [ADDR_W-1:0]     axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_W-1:0]     axi_rdata,
    output logic                  axi_rvalid,
    input  logic                  axi_rready
);

    state_t                 state_q, state_d;
    logic [DEPTH_LG2-1:0]   addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic                   step_q, step_d;
    logic [8:0]             cnt_q, cnt_d;   // write beats taken, or read beats issued to RAM
    logic [8:0]             acc_q, acc_d;
    logic                   ram_vld_q;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0]      skid_q, skid_d;
    logic                   we, re, pop, out_free;
    logic [1:0]             occ;
    logic [DATA_W-1:0]      ram_dout;
    logic                   unused_ok;

    assign unused_ok = ^{axi_awid, axi_arid, axi_awsize, axi_arsize,
                         axi_awaddr[ADDR_W-1:DEPTH_LG2], axi_araddr[ADDR_W-1:DEPTH_LG2]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        we         = 1'b0;
        re         = 1'b0;
        pop        = rvalid_q & axi_rready;
        out_free   = ~rvalid_q | pop;
        occ        = {1'b0, rvalid_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};

        unique case (state_q)
            IDLE: begin
                if (axi_awvalid) begin
                    addr_d  = axi_awaddr[DEPTH_LG2-1:0];
                    len_d   = axi_awlen;
                    step_d  = burst_step(axi_awburst);
                    cnt_d   = '0;
                    state_d = WR_DATA;
                end else if (axi_arvalid) begin
                    addr_d  = axi_araddr[DEPTH_LG2-1:0];
                    len_d   = axi_arlen;
                    step_d  = burst_step(axi_arburst);
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RD_ADDR;
                end
            end
            WR_DATA: begin
                if (axi_wvalid) begin
                    we     = 1'b1;
                    addr_d = addr_q + {{(DEPTH_LG2-1){1'b0}}, step_q};
                    cnt_d  = cnt_q + 9'd1;
                    if (cnt_q == {1'b0, len_q}) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_ADDR, RD_DATA: begin
                // Issue only while the output and skid registers can absorb the result.
                if (cnt_q <= {1'b0, len_q} && (occ - {1'b0, pop}) < 2'd2) begin
                    re     = 1'b1;
                    addr_d = addr_q + {{(DEPTH_LG2-1){1'b0}}, step_q};
                    cnt_d  = cnt_q + 9'd1;
                end
                if (state_q == RD_ADDR) begin
                    state_d = RD_DATA;
                end else if (pop) begin
                    acc_d = acc_q + 9'd1;
                    if (acc_q == {1'b0, len_q}) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (out_free) begin
            if (skid_vld_q) begin
                rvalid_d   = 1'b1;
                rdata_d    = skid_q;
                skid_vld_d = ram_vld_q;
                skid_d     = ram_dout;
            end else begin
                rvalid_d = ram_vld_q;
                if (ram_vld_q) begin
                    rdata_d = ram_dout;
                end
            end
        end else if (ram_vld_q) begin
            skid_vld_d = 1'b1;
            skid_d     = ram_dout;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            step_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            ram_vld_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ram_vld_q  <= re;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    sdp_ram_be #(
        .DATA_W    (DATA_W),
        .DEPTH_LG2 (DEPTH_LG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (addr_q),
        .wdata_i (axi_wdata),
        .wbe_i   (axi_wstrb),
        .re_i    (re),
        .raddr_i (addr_q),
        .rdata_o (ram_dout)
    );

    assign axi_awready = (state_q == IDLE);
    assign axi_arready = (state_q == IDLE);
    assign axi_wready  = (state_q == WR_DATA);
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: bursts, backpressure, wrap, strobes, reset.
module tb_axi_ram_slave;

    logic        clk;
    logic        reset;
    logic [7:0]  axi_awid;
    logic [21:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [15:0] axi_wdata;
    logic [1:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [7:0]  axi_arid;
    logic [21:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [15:0] axi_rdata;
    logic        axi_rvalid;
    logic        axi_rready;

    int n_assert;
    int n_fail;

    logic [15:0] wbuf [256];
    logic [15:0] ebuf [256];
    logic [15:0] rbuf [256];

    axi_ram_slave dut (
        .clk         (clk),
        .reset       (reset),
        .axi_awid    (axi_awid),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_beats(input int len, input logic [1:0] strb);
        check("w_ready", 32'(axi_wready), 1);
        for (int i = 0; i <= len; i++) begin
            axi_wdata  = wbuf[i];
            axi_wstrb  = strb;
            axi_wvalid = 1'b1;
            @(posedge clk); #1;
        end
        axi_wvalid = 1'b0;
        check("w_done", 32'(axi_wready), 0);
    endtask

    task automatic axi_write(input logic [21:0] addr, input int len,
                             input logic [1:0] burst, input logic [1:0] strb);
        int t;
        t = 0;
        while (!axi_awready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("aw_ready", 32'(axi_awready), 1);
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        axi_awburst = burst;
        axi_awvalid = 1'b1;
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        check("aw_busy", 32'(axi_awready), 0);
        write_beats(len, strb);
    endtask

    task automatic read_issue(input logic [21:0] addr, input int len, input logic [1:0] burst);
        check("ar_ready", 32'(axi_arready), 1);
        axi_araddr  = addr;
        axi_arlen   = 8'(len);
        axi_arburst = burst;
        axi_arvalid = 1'b1;
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
    endtask

    // Called #1 after the accept edge; k counts cycles from that edge.
    task automatic read_collect(input int len, input bit toggle, output int first_k, output int last_k);
        int k, got;
        bit hold;
        logic [15:0] prev;
        k = 0; got = 0; hold = 1'b0; prev = '0;
        first_k = -1; last_k = -1;
        while (got <= len && k < 2000) begin
            if (hold) begin
                check("r_hold_vld", 32'(axi_rvalid), 1);
                check("r_hold_data", 32'(axi_rdata), 32'(prev));
            end
            axi_rready = toggle ? (k % 2 == 0) : 1'b1;
            if (axi_rvalid && first_k < 0) first_k = k;
            if (axi_rvalid && axi_rready) begin
                rbuf[got] = axi_rdata;
                got++;
                last_k = k;
            end
            hold = axi_rvalid && !axi_rready;
            prev = axi_rdata;
            @(posedge clk); #1;
            k++;
        end
        axi_rready = 1'b0;
        check("r_beats", got, len + 1);
        check("r_end_vld", 32'(axi_rvalid), 0);
        check("r_end_idle", 32'(axi_arready), 1);
    endtask

    task automatic check_rbuf(input string tag, input int n);
        for (int i = 0; i < n; i++) check(tag, 32'(rbuf[i]), 32'(ebuf[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fk, lk;
        n_assert = 0; n_fail = 0;
        reset = 1'b0;
        axi_awid = 8'h11; axi_awaddr = '0; axi_awlen = '0; axi_awsize = 3'd1;
        axi_awburst = 2'b01; axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = 2'b11;
        axi_wvalid = 1'b0; axi_arid = 8'h22; axi_araddr = '0; axi_arlen = '0;
        axi_arsize = 3'd1; axi_arburst = 2'b01; axi_arvalid = 1'b0; axi_rready = 1'b0;

        // 1. reset values, single write/read with latency
        #22;
        check("rst_awready", 32'(axi_awready), 1);
        check("rst_arready", 32'(axi_arready), 1);
        check("rst_wready", 32'(axi_wready), 0);
        check("rst_rvalid", 32'(axi_rvalid), 0);
        check("rst_rdata", 32'(axi_rdata), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_awready", 32'(axi_awready), 1);
        check("rel_wready", 32'(axi_wready), 0);
        check("rel_rvalid", 32'(axi_rvalid), 0);
        wbuf[0] = 16'hA5A5;
        axi_write(22'h000010, 0, 2'b01, 2'b11);
        read_issue(22'h000010, 0, 2'b01);
        read_collect(0, 1'b0, fk, lk);
        check("t1_latency", fk, 2);
        check("t1_data", 32'(rbuf[0]), 32'h0000A5A5);

        // 2. full-length INCR burst, streaming read
        for (int i = 0; i < 256; i++) begin
            wbuf[i] = 16'(i);
            ebuf[i] = 16'(i);
        end
        axi_write(22'h000100, 255, 2'b01, 2'b11);
        read_issue(22'h000100, 255, 2'b01);
        read_collect(255, 1'b0, fk, lk);
        check("t2_latency", fk, 2);
        check("t2_stream", lk - fk, 255);
        check_rbuf("t2_data", 256);

        // 3. 8-beat read with toggling rready
        read_issue(22'h000100, 7, 2'b01);
        read_collect(7, 1'b1, fk, lk);
        check_rbuf("t3_data", 8);

        // 4. simultaneous aw/ar: write first, then read sees new data
        wbuf[0] = 16'hC0DE; wbuf[1] = 16'hCAFE;
        check("t4_ar_ready", 32'(axi_arready), 1);
        axi_awaddr = 22'h000400; axi_awlen = 8'd1; axi_awburst = 2'b01; axi_awvalid = 1'b1;
        axi_araddr = 22'h000400; axi_arlen = 8'd1; axi_arburst = 2'b01; axi_arvalid = 1'b1;
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        check("t4_ar_held", 32'(axi_arready), 0);
        write_beats(1, 2'b11);
        check("t4_ar_back", 32'(axi_arready), 1);
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        read_collect(1, 1'b0, fk, lk);
        check("t4_latency", fk, 2);
        ebuf[0] = 16'hC0DE; ebuf[1] = 16'hCAFE;
        check_rbuf("t4_data", 2);

        // 5. INCR wrap at top of RAM, FIXED burst
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        axi_write(22'h000FFE, 3, 2'b01, 2'b11);
        read_issue(22'h000000, 1, 2'b01);
        read_collect(1, 1'b0, fk, lk);
        ebuf[0] = 16'h3333; ebuf[1] = 16'h4444;
        check_rbuf("t5_wrap_low", 2);
        read_issue(22'h000FFE, 3, 2'b01);
        read_collect(3, 1'b0, fk, lk);
        ebuf[0] = 16'h1111; ebuf[1] = 16'h2222; ebuf[2] = 16'h3333; ebuf[3] = 16'h4444;
        check_rbuf("t5_wrap_all", 4);
        wbuf[0] = 16'h0000; wbuf[1] = 16'h5555;
        axi_write(22'h000200, 1, 2'b01, 2'b11);
        wbuf[0] = 16'hAAA1; wbuf[1] = 16'hAAA2; wbuf[2] = 16'hAAA3;
        axi_write(22'h000200, 2, 2'b00, 2'b11);
        read_issue(22'h000200, 1, 2'b01);
        read_collect(1, 1'b0, fk, lk);
        ebuf[0] = 16'hAAA3; ebuf[1] = 16'h5555;
        check_rbuf("t5_fixed", 2);

        // 6. byte strobes
        wbuf[0] = 16'h1234;
        axi_write(22'h000500, 0, 2'b01, 2'b11);
        wbuf[0] = 16'hBEEF;
        axi_write(22'h000500, 0, 2'b01, 2'b01);
        read_issue(22'h000500, 0, 2'b01);
        read_collect(0, 1'b0, fk, lk);
        check("t6_strb", 32'(rbuf[0]), 32'h000012EF);

        // 6b. reset mid-write: beats already written survive
        for (int i = 0; i < 8; i++) wbuf[i] = 16'h3000 + 16'(i);
        axi_awaddr = 22'h000300; axi_awlen = 8'd7; axi_awburst = 2'b01; axi_awvalid = 1'b1;
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            axi_wdata = wbuf[i]; axi_wstrb = 2'b11; axi_wvalid = 1'b1;
            @(posedge clk); #1;
        end
        axi_wvalid = 1'b0;
        check("t6_mid_wr", 32'(axi_wready), 1);
        #1 reset = 1'b0;
        #1;
        check("t6_rstw_awready", 32'(axi_awready), 1);
        check("t6_rstw_arready", 32'(axi_arready), 1);
        check("t6_rstw_wready", 32'(axi_wready), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        read_issue(22'h000300, 2, 2'b01);
        read_collect(2, 1'b0, fk, lk);
        ebuf[0] = 16'h3000; ebuf[1] = 16'h3001; ebuf[2] = 16'h3002;
        check_rbuf("t6_kept", 3);

        // 6c. reset mid-read clears rvalid/rdata at once
        read_issue(22'h000105, 7, 2'b01);
        axi_rready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("t6_mid_rvalid", 32'(axi_rvalid), 1);
        check("t6_mid_rdata", 32'(axi_rdata), 32'h5);
        #1 reset = 1'b0;
        #1;
        check("t6_rstr_rvalid", 32'(axi_rvalid), 0);
        check("t6_rstr_rdata", 32'(axi_rdata), 0);
        check("t6_rstr_arready", 32'(axi_arready), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        wbuf[0] = 16'h7777; wbuf[1] = 16'h8888;
        axi_write(22'h000600, 1, 2'b01, 2'b11);
        read_issue(22'h000600, 1, 2'b01);
        read_collect(1, 1'b0, fk, lk);
        check("t6_after_lat", fk, 2);
        ebuf[0] = 16'h7777; ebuf[1] = 16'h8888;
        check_rbuf("t6_after", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
